// File: rtl/layer_argmax.sv
// Argmax over the final layer's parallel outputs: captures all values on a valid
// strobe, then scans them with a single signed comparator and reports the winner.
`timescale 1ns/1ps
module layer_argmax #(
    parameter int NN        = 10,
    parameter int dataWidth = 16,
    parameter int idxWidth  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NN-1:0]           i_valid,
    input  logic [NN*dataWidth-1:0] i_data,
    output logic                    o_valid,
    output logic [idxWidth-1:0]     o_index,
    output logic [dataWidth-1:0]    o_max,
    output logic                    o_busy,
    output logic                    o_overrun
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                      state, state_next;
    logic signed [dataWidth-1:0] cap [NN];
    logic signed [dataWidth-1:0] run_max;
    logic        [idxWidth-1:0]  run_idx;
    logic        [idxWidth-1:0]  cnt;
    logic signed [dataWidth-1:0] cand;
    logic                        take;
    logic                        last;
    logic                        start;
    logic                        valid_unused;

    // Only bit 0 of the per-neuron valid vector carries information.
    assign valid_unused = ^i_valid[NN-1:1];

    assign start = (state == IDLE) && i_valid[0];
    assign cand  = cap[cnt];
    assign take  = cand > run_max;
    assign last  = (cnt == idxWidth'(NN - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_valid[0]) state_next = SCAN;
            SCAN:    if (last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        o_valid = (state == DONE);
        o_busy  = (state != IDLE);
    end

    // Strictly-greater compare keeps the lower index on ties.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NN; k++) cap[k] <= '0;
            run_max   <= '0;
            run_idx   <= '0;
            cnt       <= '0;
            o_index   <= '0;
            o_max     <= '0;
            o_overrun <= 1'b0;
        end else begin
            if (start) begin
                for (int k = 0; k < NN; k++) cap[k] <= i_data[k*dataWidth +: dataWidth];
                run_max <= i_data[0 +: dataWidth];
                run_idx <= '0;
                cnt     <= idxWidth'(1);
            end else if (state == SCAN) begin
                cnt <= cnt + 1'b1;
                if (take) begin
                    run_max <= cand;
                    run_idx <= cnt;
                end
                if (last) begin
                    o_max   <= take ? cand : run_max;
                    o_index <= take ? cnt : run_idx;
                end
            end
            if ((state != IDLE) && i_valid[0]) o_overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_layer_argmax.sv
// Directed bench for layer_argmax: timing, signed compare, ties, overrun,
// asynchronous reset abort and back-to-back throughput.
`timescale 1ns/1ps
module tb_layer_argmax;
    localparam int NN = 10;
    localparam int DW = 16;
    localparam int IW = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [NN-1:0]    i_valid;
    logic [NN*DW-1:0] i_data;
    logic             o_valid;
    logic [IW-1:0]    o_index;
    logic [DW-1:0]    o_max;
    logic             o_busy;
    logic             o_overrun;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    logic [DW-1:0] vals [NN];

    layer_argmax #(.NN(NN), .dataWidth(DW), .idxWidth(IW)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data),
        .o_valid(o_valid), .o_index(o_index), .o_max(o_max),
        .o_busy(o_busy), .o_overrun(o_overrun)
    );

    always #5 clk = ~clk;

    task tick;
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task load;
        for (int k = 0; k < NN; k++) i_data[k*DW +: DW] = vals[k];
    endtask

    // Issue one frame and wait (bounded) for its o_valid pulse.
    task run_frame(output int lat, output logic [IW-1:0] idx, output logic [DW-1:0] mx,
                   output int vcyc);
        load;
        i_valid = '1;
        tick;
        i_valid = '0;
        lat = 0;
        while (o_valid !== 1'b1 && lat < 40) begin
            tick;
            lat++;
        end
        idx  = o_index;
        mx   = o_max;
        vcyc = cycle;
    endtask

    task test_reset;
        rst = 1'b0; i_valid = '0; i_data = '0;
        tick; tick;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", o_valid); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", o_busy); end
        checks++; if (o_index !== 4'd0) begin errors++; $display("FAIL reset_index got %0d want 0", o_index); end
        checks++; if (o_max !== 16'h0000) begin errors++; $display("FAIL reset_max got %h want 0000", o_max); end
        checks++; if (o_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", o_overrun); end
        #2 rst = 1'b1;
        tick;
    endtask

    task test_basic;
        vals = '{16'h0500, 16'h0300, 16'h0900, 16'h0100, 16'h0000,
                 16'h0200, 16'h0700, 16'h0800, 16'h0400, 16'h0600};
        load;
        i_valid = '1;
        tick;
        i_valid = '0;
        i_data  = {NN{16'h7FFF}};
        checks++; if (o_busy !== 1'b1 || o_valid !== 1'b0) begin errors++; $display("FAIL basic_start busy=%b valid=%b want busy=1 valid=0", o_busy, o_valid); end
        for (int n = 1; n < NN - 1; n++) begin
            tick;
            checks++; if (o_valid !== 1'b0 || o_busy !== 1'b1) begin errors++; $display("FAIL basic_scan edge E+%0d busy=%b valid=%b want busy=1 valid=0", n, o_busy, o_valid); end
        end
        tick;
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", o_valid); end
        checks++; if (o_index !== 4'd2) begin errors++; $display("FAIL basic_index got %0d want 2", o_index); end
        checks++; if (o_max !== 16'h0900) begin errors++; $display("FAIL basic_max got %h want 0900", o_max); end
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL basic_done_busy got %b want 1", o_busy); end
        tick;
        checks++; if (o_valid !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL basic_end busy=%b valid=%b want 0 0", o_busy, o_valid); end
        checks++; if (o_index !== 4'd2 || o_max !== 16'h0900) begin errors++; $display("FAIL basic_hold idx=%0d max=%h want 2 0900", o_index, o_max); end
    endtask

    task test_signed;
        int lat, vc;
        logic [IW-1:0] idx;
        logic [DW-1:0] mx;
        vals = '{16'hF600, 16'hFD00, 16'hF900, 16'hFB00, 16'hF800,
                 16'hFC00, 16'hFA00, 16'hF700, 16'hF400, 16'hEC00};
        run_frame(lat, idx, mx, vc);
        checks++; if (lat != NN - 1) begin errors++; $display("FAIL neg_latency got %0d want %0d", lat, NN - 1); end
        checks++; if (idx !== 4'd1 || mx !== 16'hFD00) begin errors++; $display("FAIL neg_result idx=%0d max=%h want 1 FD00", idx, mx); end
        tick;
        vals = '{16'h8000, 16'hFFFF, 16'h8000, 16'h8000, 16'h8000,
                 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000};
        run_frame(lat, idx, mx, vc);
        checks++; if (idx !== 4'd1 || mx !== 16'hFFFF) begin errors++; $display("FAIL minval_result idx=%0d max=%h want 1 FFFF", idx, mx); end
        tick;
        vals = '{16'h8000, 16'hFFFF, 16'h0100, 16'h8000, 16'h8000,
                 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000};
        run_frame(lat, idx, mx, vc);
        checks++; if (idx !== 4'd2 || mx !== 16'h0100) begin errors++; $display("FAIL mixed_sign idx=%0d max=%h want 2 0100", idx, mx); end
        tick;
    endtask

    task test_tie_ends;
        int lat, vc;
        logic [IW-1:0] idx;
        logic [DW-1:0] mx;
        vals = '{16'h0400, 16'h0100, 16'h0100, 16'h0100, 16'h0100,
                 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0400};
        run_frame(lat, idx, mx, vc);
        checks++; if (idx !== 4'd0 || mx !== 16'h0400) begin errors++; $display("FAIL tie_result idx=%0d max=%h want 0 0400", idx, mx); end
        tick;
        vals = '{16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100,
                 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0500};
        run_frame(lat, idx, mx, vc);
        checks++; if (idx !== 4'd9 || mx !== 16'h0500) begin errors++; $display("FAIL last_result idx=%0d max=%h want 9 0500", idx, mx); end
        tick;
    endtask

    task test_overrun;
        int lat, vc;
        logic [IW-1:0] idx;
        logic [DW-1:0] mx;
        vals = '{16'h0500, 16'h0300, 16'h0900, 16'h0100, 16'h0000,
                 16'h0200, 16'h0700, 16'h0800, 16'h0400, 16'h0600};
        load;
        i_valid = '1;
        tick;
        i_valid = '0;
        tick; tick;
        vals = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                 16'h0000, 16'h0000, 16'h7000, 16'h0000, 16'h0000};
        load;
        i_valid = '1;
        tick;
        i_valid = '0;
        checks++; if (o_overrun !== 1'b1) begin errors++; $display("FAIL overrun_set got %b want 1", o_overrun); end
        lat = 3;
        while (o_valid !== 1'b1 && lat < 40) begin
            tick;
            lat++;
        end
        checks++; if (lat != NN - 1) begin errors++; $display("FAIL overrun_latency got %0d want %0d", lat, NN - 1); end
        checks++; if (o_index !== 4'd2 || o_max !== 16'h0900) begin errors++; $display("FAIL overrun_result idx=%0d max=%h want 2 0900", o_index, o_max); end
        tick;
        vals = '{16'h0010, 16'h0010, 16'h0010, 16'h0010, 16'h0020,
                 16'h0010, 16'h0010, 16'h0010, 16'h0010, 16'h0010};
        run_frame(lat, idx, mx, vc);
        checks++; if (lat != NN - 1) begin errors++; $display("FAIL third_latency got %0d want %0d", lat, NN - 1); end
        checks++; if (idx !== 4'd4 || mx !== 16'h0020) begin errors++; $display("FAIL third_result idx=%0d max=%h want 4 0020", idx, mx); end
        checks++; if (o_overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky got %b want 1", o_overrun); end
        tick;
    endtask

    task test_reset_mid_scan;
        int lat, vc, seen;
        logic [IW-1:0] idx;
        logic [DW-1:0] mx;
        vals = '{16'h0500, 16'h0300, 16'h0900, 16'h0100, 16'h0000,
                 16'h0200, 16'h0700, 16'h0800, 16'h0400, 16'h0600};
        load;
        i_valid = '1;
        tick;
        i_valid = '0;
        tick; tick; tick;
        #2 rst = 1'b0;
        #1;
        checks++; if (o_busy !== 1'b0 || o_valid !== 1'b0) begin errors++; $display("FAIL abort_ctrl busy=%b valid=%b want 0 0", o_busy, o_valid); end
        checks++; if (o_index !== 4'd0 || o_max !== 16'h0000) begin errors++; $display("FAIL abort_data idx=%0d max=%h want 0 0000", o_index, o_max); end
        checks++; if (o_overrun !== 1'b0) begin errors++; $display("FAIL abort_overrun got %b want 0", o_overrun); end
        tick;
        #3 rst = 1'b1;
        seen = 0;
        for (int n = 0; n < 12; n++) begin
            tick;
            if (o_valid === 1'b1 || o_busy === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL abort_no_pulse got %0d active cycles want 0", seen); end
        vals = '{16'hF600, 16'hFD00, 16'hF900, 16'hFB00, 16'hF800,
                 16'hFC00, 16'hFA00, 16'hF700, 16'hF400, 16'hEC00};
        run_frame(lat, idx, mx, vc);
        checks++; if (lat != NN - 1 || idx !== 4'd1 || mx !== 16'hFD00) begin errors++; $display("FAIL after_reset lat=%0d idx=%0d max=%h want 9 1 FD00", lat, idx, mx); end
        tick;
    endtask

    task test_back_to_back;
        int lat, vc, prev;
        logic [IW-1:0] idx;
        logic [DW-1:0] mx;
        int winners [5];
        winners = '{0, 3, 5, 8, 9};
        prev = 0;
        for (int f = 0; f < 5; f++) begin
            for (int k = 0; k < NN; k++) vals[k] = 16'h0040 + DW'(k);
            vals[winners[f]] = 16'h0200 + DW'(f);
            run_frame(lat, idx, mx, vc);
            checks++; if (idx !== IW'(winners[f]) || mx !== 16'h0200 + DW'(f)) begin errors++; $display("FAIL b2b_result frame %0d idx=%0d max=%h want %0d %h", f, idx, mx, winners[f], 16'h0200 + f); end
            if (f > 0) begin
                checks++; if (vc - prev != NN + 1) begin errors++; $display("FAIL b2b_spacing frame %0d got %0d want %0d", f, vc - prev, NN + 1); end
            end
            prev = vc;
            tick;
            checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_fall frame %0d got %b want 0", f, o_busy); end
        end
        checks++; if (o_overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun got %b want 0", o_overrun); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_signed;
        test_tie_ends;
        test_overrun;
        test_reset_mid_scan;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
